epb_wb_bridge: RTL and testbench

- Downstream of the EPB pad/clock infrastructure stage, in the epb_clk domain.
- Consumes the buffered EPB data bus and control strobes, and decodes each PowerPC EPB access into a single Wishbone classic master cycle.
- Returns read data and drives the data-bus output enable and the EPB ready strobe back through the pad stage.
- One transaction in flight at a time; EPB bit numbering is big-endian [0:31].

---
 rtl/epb_wb_bridge.sv | 166 ++++++++++++++++
 tb/tb_epb_wb_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/epb_wb_bridge.sv
// EPB (PowerPC external peripheral bus) to Wishbone classic master bridge, one access in flight.
// Optional build macro EPB_WB_TIMEOUT_EN adds a WAIT timeout with a sticky timeout_o flag.
module epb_wb_bridge #(
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic              epb_clk,
  input  logic              epb_rst,
  input  logic              epb_cs_n,
  input  logic              epb_r_w_n,
  input  logic [3:0]        epb_be_n,
  input  logic [ADDR_W-1:0] epb_addr,
  input  logic [31:0]       epb_data_i,
  output logic [31:0]       epb_data_o,
  output logic              epb_data_oe_n,
  output logic              epb_rdy,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              timeout_o
);

  typedef enum logic [1:0] {StIdle, StWait, StRdy, StHold} state_e;

  state_e            state_q, state_d;
  logic              cs_n_q, r_w_n_q;
  logic [3:0]        be_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic              cyc_q, cyc_d, we_q, we_d, rdy_q, rdy_d, oe_n_q, oe_n_d;
  logic              abort_q, abort_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d, rdata_q, rdata_d;
  logic              to_fire, term;

`ifdef EPB_WB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  // Ack or err on the same edge as the timeout takes priority over it.
  assign to_fire = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) &&
                   !wbm_ack_i && !wbm_err_i;

  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == StWait) ? cnt_q + 1'b1 : '0;
      timeout_q <= timeout_q | to_fire;
    end
  end
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign term = wbm_ack_i | wbm_err_i | to_fire;

  // Input capture register; the FSM only ever looks at these copies.
  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      cs_n_q  <= 1'b1;
      r_w_n_q <= 1'b1;
      be_n_q  <= 4'hF;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      cs_n_q  <= epb_cs_n;
      r_w_n_q <= epb_r_w_n;
      be_n_q  <= epb_be_n;
      addr_q  <= epb_addr;
      data_q  <= epb_data_i;
    end
  end

  always_ff @(posedge epb_clk) begin
    if (epb_rst) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!cs_n_q) state_d = StWait;
      // An aborted access still finishes on the bus but skips the EPB handshake.
      StWait: if (term) state_d = (abort_q || cs_n_q) ? StIdle : StRdy;
      StRdy:  state_d = StHold;
      StHold: if (cs_n_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    if (state_q == StIdle && !cs_n_q) begin
      adr_d = addr_q;
      we_d  = ~r_w_n_q;
      sel_d = ~be_n_q;
      dat_d = data_q;
    end
    if (state_q == StWait && term && !we_q) begin
      if (wbm_err_i)      rdata_d = ERR_DATA;
      else if (wbm_ack_i) rdata_d = wbm_dat_i;
      else                rdata_d = 32'hDEAD_C0DE;
    end
    cyc_d   = (state_d == StWait);
    rdy_d   = (state_d == StRdy);
    abort_d = (state_q == StWait) ? (abort_q | cs_n_q) : 1'b0;
    if (state_d == StRdy)       oe_n_d = we_q;
    else if (state_d == StHold) oe_n_d = oe_n_q;
    else                        oe_n_d = 1'b1;
  end

  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      abort_q <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      oe_n_q  <= oe_n_d;
      abort_q <= abort_d;
    end
  end

  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign epb_data_o    = rdata_q;
  assign epb_rdy       = rdy_q;
  assign epb_data_oe_n = oe_n_q;

endmodule

// File: tb/tb_epb_wb_bridge.sv
// Directed bench for epb_wb_bridge: reads, writes, err, abort, reset mid-cycle, optional timeout.
module tb_epb_wb_bridge;

  logic        epb_clk = 1'b0;
  logic        epb_rst, epb_cs_n, epb_r_w_n;
  logic [3:0]  epb_be_n;
  logic [24:0] epb_addr;
  logic [31:0] epb_data_i, epb_data_o, wbm_dat_o, wbm_dat_i;
  logic        epb_data_oe_n, epb_rdy, wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [24:0] wbm_adr_o;
  logic        wbm_ack_i, wbm_err_i, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 epb_clk = ~epb_clk;

  epb_wb_bridge #(
    .ADDR_W        (25),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .epb_clk      (epb_clk),
    .epb_rst      (epb_rst),
    .epb_cs_n     (epb_cs_n),
    .epb_r_w_n    (epb_r_w_n),
    .epb_be_n     (epb_be_n),
    .epb_addr     (epb_addr),
    .epb_data_i   (epb_data_i),
    .epb_data_o   (epb_data_o),
    .epb_data_oe_n(epb_data_oe_n),
    .epb_rdy      (epb_rdy),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .timeout_o    (timeout_o)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge epb_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd, input logic [3:0] be_n, input logic [24:0] a,
                       input logic [31:0] d);
    epb_cs_n = 1'b0; epb_r_w_n = rd; epb_be_n = be_n; epb_addr = a; epb_data_i = d;
  endtask

  initial begin
    epb_rst = 1'b1; epb_cs_n = 1'b1; epb_r_w_n = 1'b1; epb_be_n = 4'hF;
    epb_addr = '0; epb_data_i = '0; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    tick(2);
    epb_rst = 1'b0;
    check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("rst_oe_n", {31'd0, epb_data_oe_n}, 32'd1);
    check("rst_rdy", {31'd0, epb_rdy}, 32'd0);
    check("rst_data_o", epb_data_o, 32'd0);
    check("rst_adr", {7'd0, wbm_adr_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);

    // Full-word read, slave acks one cycle after stb.
    start(1'b1, 4'h0, 25'h000_0123, 32'h0);
    tick();
    check("rd_cyc_lat1", {31'd0, wbm_cyc_o}, 32'd0);
    tick();
    check("rd_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    check("rd_stb", {31'd0, wbm_stb_o}, 32'd1);
    check("rd_we", {31'd0, wbm_we_o}, 32'd0);
    check("rd_sel", {28'd0, wbm_sel_o}, 32'hF);
    check("rd_adr", {7'd0, wbm_adr_o}, 32'h123);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    check("rd_rdy", {31'd0, epb_rdy}, 32'd1);
    check("rd_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    check("rd_oe_n", {31'd0, epb_data_oe_n}, 32'd0);
    check("rd_data", epb_data_o, 32'h1234_5678);
    tick();
    check("rd_rdy_pulse", {31'd0, epb_rdy}, 32'd0);
    check("rd_oe_n_hold", {31'd0, epb_data_oe_n}, 32'd0);
    epb_cs_n = 1'b1;
    tick();
    check("rd_oe_n_hold2", {31'd0, epb_data_oe_n}, 32'd0);
    check("rd_data_hold", epb_data_o, 32'h1234_5678);
    tick();
    check("rd_oe_n_rel", {31'd0, epb_data_oe_n}, 32'd1);

    // Write with partial byte enables, slave delays ack.
    start(1'b0, 4'b0011, 25'h000_0040, 32'hCAFE_F00D);
    tick(2);
    check("wr_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    check("wr_we", {31'd0, wbm_we_o}, 32'd1);
    check("wr_sel", {28'd0, wbm_sel_o}, 32'hC);
    check("wr_adr", {7'd0, wbm_adr_o}, 32'h40);
    check("wr_dat", wbm_dat_o, 32'hCAFE_F00D);
    epb_data_i = 32'h0; epb_addr = 25'h1;
    tick(2);
    check("wr_cyc_wait", {31'd0, wbm_cyc_o}, 32'd1);
    check("wr_dat_stable", wbm_dat_o, 32'hCAFE_F00D);
    check("wr_adr_stable", {7'd0, wbm_adr_o}, 32'h40);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("wr_rdy", {31'd0, epb_rdy}, 32'd1);
    check("wr_oe_n", {31'd0, epb_data_oe_n}, 32'd1);
    check("wr_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    tick();
    check("wr_rdy_pulse", {31'd0, epb_rdy}, 32'd0);
    check("wr_oe_n_hold", {31'd0, epb_data_oe_n}, 32'd1);
    epb_cs_n = 1'b1;
    tick(2);

    // Read terminated by err together with ack: err wins.
    start(1'b1, 4'h0, 25'h000_0005, 32'h0);
    tick(2);
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h5555_5555;
    tick();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    check("err_data", epb_data_o, 32'hFFFF_FFFF);
    check("err_rdy", {31'd0, epb_rdy}, 32'd1);
    tick();
    check("err_rdy_pulse", {31'd0, epb_rdy}, 32'd0);
    epb_cs_n = 1'b1;
    tick(2);

    // cs_n released mid-WAIT: bus cycle completes, no rdy, oe_n stays high.
    start(1'b1, 4'h0, 25'h000_0009, 32'h0);
    tick(2);
    check("ab_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    epb_cs_n = 1'b1;
    tick(4);
    check("ab_cyc_held", {31'd0, wbm_cyc_o}, 32'd1);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_0BAD;
    tick();
    wbm_ack_i = 1'b0;
    check("ab_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    check("ab_no_rdy", {31'd0, epb_rdy}, 32'd0);
    check("ab_oe_n", {31'd0, epb_data_oe_n}, 32'd1);
    tick();
    check("ab_no_rdy2", {31'd0, epb_rdy}, 32'd0);
    check("ab_idle_cyc", {31'd0, wbm_cyc_o}, 32'd0);

    // Follow-up read after the abort.
    start(1'b1, 4'h0, 25'h000_0007, 32'h0);
    tick(2);
    check("pa_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    check("pa_adr", {7'd0, wbm_adr_o}, 32'h7);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0F0F;
    tick();
    wbm_ack_i = 1'b0;
    check("pa_rdy", {31'd0, epb_rdy}, 32'd1);
    check("pa_data", epb_data_o, 32'hA5A5_0F0F);
    check("pa_oe_n", {31'd0, epb_data_oe_n}, 32'd0);
    epb_cs_n = 1'b1;
    tick(2);
    check("pa_oe_n_rel", {31'd0, epb_data_oe_n}, 32'd1);

    // Reset while in WAIT.
    start(1'b1, 4'h0, 25'h000_0011, 32'h0);
    tick(2);
    check("rw_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    epb_rst = 1'b1; epb_cs_n = 1'b1;
    tick();
    epb_rst = 1'b0;
    check("rw_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rw_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("rw_oe_n", {31'd0, epb_data_oe_n}, 32'd1);
    check("rw_rdy", {31'd0, epb_rdy}, 32'd0);
    check("rw_adr", {7'd0, wbm_adr_o}, 32'd0);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("rw_no_rdy", {31'd0, epb_rdy}, 32'd0);
    tick();

`ifdef EPB_WB_TIMEOUT_EN
    // Slave never answers: timeout after 8 WAIT cycles.
    start(1'b1, 4'h0, 25'h000_0021, 32'h0);
    tick(2);
    tick(7);
    check("to_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    check("to_flag_before", {31'd0, timeout_o}, 32'd0);
    tick();
    check("to_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    check("to_data", epb_data_o, 32'hDEAD_C0DE);
    check("to_rdy", {31'd0, epb_rdy}, 32'd1);
    check("to_flag", {31'd0, timeout_o}, 32'd1);
    epb_cs_n = 1'b1;
    tick(3);
    check("to_sticky", {31'd0, timeout_o}, 32'd1);
`else
    // Without the timeout option the bus cycle waits indefinitely.
    start(1'b1, 4'h0, 25'h000_0021, 32'h0);
    tick(2 + 20);
    check("nto_cyc_wait", {31'd0, wbm_cyc_o}, 32'd1);
    check("nto_flag", {31'd0, timeout_o}, 32'd0);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_00C3;
    tick();
    wbm_ack_i = 1'b0;
    check("nto_data", epb_data_o, 32'h0000_00C3);
    epb_cs_n = 1'b1;
    tick(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
